// File: rtl/picorv32_mem_responder_if.sv
// Native picorv32 memory bus: request (valid/instr/addr/wdata/wstrb) and response (ready/rdata).
// master = core side, slave = memory responder side.
interface picorv32_mem_responder_if;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/picorv32_mem_responder.sv
// Word-addressed memory model answering the picorv32 native bus with programmable wait states,
// sticky protocol/range error flags and transfer counters.
module picorv32_mem_responder #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned MAX_WAIT   = 7,
   parameter logic [31:0] ERR_RDATA  = 32'hDEADBEEF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [3:0]                     wait_cycles,
   picorv32_mem_responder_if.slave        bus,
   output logic                           protocol_err,
   output logic                           range_err,
   output logic [31:0]                    txn_count,
   output logic [31:0]                    fetch_count
);

   localparam int unsigned Depth = 1 << ADDR_WIDTH;
   localparam logic [3:0] MaxWait = (MAX_WAIT > 15) ? 4'd15 : 4'(MAX_WAIT);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        instr_q, instr_d;
   logic        ready_q, ready_d;
   logic [31:0] rdata_q, rdata_d;
   logic        perr_q, perr_d;
   logic        rerr_q, rerr_d;
   logic [31:0] txn_q, txn_d;
   logic [31:0] fetch_q, fetch_d;

   // Not cleared by reset; zero only at time 0.
   logic [31:0] mem_q [Depth] = '{default: '0};

   // Request as seen on the completing edge: live inputs when finishing straight from IDLE,
   // otherwise the values latched at acceptance.
   logic [31:0]           req_addr;
   logic [31:0]           req_wdata;
   logic [3:0]            req_wstrb;
   logic                  req_instr;
   logic [ADDR_WIDTH-1:0] req_idx;
   logic                  req_oor;
   logic                  go_resp;
   logic                  wr_en;
   logic [3:0]            wait_n;

   always_comb begin
      if (state_q == StIdle) begin
         req_addr  = bus.mem_addr;
         req_wdata = bus.mem_wdata;
         req_wstrb = bus.mem_wstrb;
         req_instr = bus.mem_instr;
      end else begin
         req_addr  = addr_q;
         req_wdata = wdata_q;
         req_wstrb = wstrb_q;
         req_instr = instr_q;
      end
   end

   assign req_idx = req_addr[ADDR_WIDTH+1:2];
   assign req_oor = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
   assign wait_n  = (wait_cycles > MaxWait) ? MaxWait : wait_cycles;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      instr_d = instr_q;
      ready_d = 1'b0;
      rdata_d = 32'd0;
      perr_d  = perr_q;
      rerr_d  = rerr_q;
      txn_d   = txn_q;
      fetch_d = fetch_q;
      go_resp = 1'b0;

      case (state_q)
         StIdle: begin
            if (bus.mem_valid) begin
               addr_d  = bus.mem_addr;
               wdata_d = bus.mem_wdata;
               wstrb_d = bus.mem_wstrb;
               instr_d = bus.mem_instr;
               cnt_d   = wait_n;
               if (wait_n == 4'd0) begin
                  go_resp = 1'b1;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            if (!bus.mem_valid || (bus.mem_addr != addr_q) || (bus.mem_wstrb != wstrb_q) ||
                (bus.mem_wdata != wdata_q)) begin
               perr_d = 1'b1;
            end
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               go_resp = 1'b1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (go_resp) begin
         state_d = StResp;
         ready_d = 1'b1;
         txn_d   = txn_q + 32'd1;
         if (req_instr) begin
            fetch_d = fetch_q + 32'd1;
         end
         if (req_oor) begin
            rerr_d = 1'b1;
            if (req_wstrb == 4'd0) begin
               rdata_d = ERR_RDATA;
            end
         end else if (req_wstrb == 4'd0) begin
            rdata_d = mem_q[req_idx];
         end
      end
   end

   // Gate on reset so a request seen while reset is held never lands in memory.
   assign wr_en = go_resp && (req_wstrb != 4'd0) && !req_oor && !reset;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (req_wstrb[b]) begin
               mem_q[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         wstrb_q <= 4'd0;
         instr_q <= 1'b0;
         ready_q <= 1'b0;
         rdata_q <= 32'd0;
         perr_q  <= 1'b0;
         rerr_q  <= 1'b0;
         txn_q   <= 32'd0;
         fetch_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         instr_q <= instr_d;
         ready_q <= ready_d;
         rdata_q <= rdata_d;
         perr_q  <= perr_d;
         rerr_q  <= rerr_d;
         txn_q   <= txn_d;
         fetch_q <= fetch_d;
      end
   end

   assign bus.mem_ready = ready_q;
   assign bus.mem_rdata = rdata_q;
   assign protocol_err  = perr_q;
   assign range_err     = rerr_q;
   assign txn_count     = txn_q;
   assign fetch_count   = fetch_q;

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Directed bench for picorv32_mem_responder: vector table of single transfers plus
// hand-written back-to-back, protocol-drop, range and mid-transfer reset sequences.
module tb_picorv32_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  wait_cycles;
   logic        protocol_err;
   logic        range_err;
   logic [31:0] txn_count;
   logic [31:0] fetch_count;

   picorv32_mem_responder_if bus_if ();

   picorv32_mem_responder #(
      .ADDR_WIDTH(8),
      .MAX_WAIT  (7),
      .ERR_RDATA (32'hDEADBEEF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wait_cycles (wait_cycles),
      .bus         (bus_if),
      .protocol_err(protocol_err),
      .range_err   (range_err),
      .txn_count   (txn_count),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [3:0]  waitc;
      logic        instr;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   int total = 0;
   int bad   = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_req(input vec_t v);
      bus_if.mem_valid = 1'b1;
      bus_if.mem_addr  = v.addr;
      bus_if.mem_wdata = v.wdata;
      bus_if.mem_wstrb = v.wstrb;
      bus_if.mem_instr = v.instr;
      wait_cycles      = v.waitc;
   endtask

   // Counts edges until mem_ready is seen (sampled 1 time unit after each edge); -1 on timeout.
   task automatic wait_ready(output int lat);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (bus_if.mem_ready) begin
            lat = i;
            break;
         end
      end
   endtask

   // Runs one transfer from IDLE and leaves the DUT back in IDLE.
   task automatic run_txn(input string name, input vec_t v);
      int          lat;
      logic [31:0] rd;
      set_req(v);
      wait_ready(lat);
      rd = bus_if.mem_rdata;
      bus_if.mem_valid = 1'b0;
      check32({name, " latency"}, 32'(lat), 32'(v.exp_lat));
      check32({name, " rdata"}, rd, v.exp_rdata);
      @(posedge clk);
      #1;
      check32({name, " ready pulse end"}, {31'd0, bus_if.mem_ready}, 32'd0);
      check32({name, " rdata idle"}, bus_if.mem_rdata, 32'd0);
   endtask

   vec_t vecs[7];
   vec_t v;
   int   lat;
   logic [3:0] rdy_seen;

   initial begin
      vecs[0] = '{32'h10, 32'hA5A5_1234, 4'hF, 4'd0,  1'b0, 32'h0,         1};
      vecs[1] = '{32'h10, 32'h0,         4'h0, 4'd0,  1'b0, 32'hA5A5_1234, 1};
      vecs[2] = '{32'h10, 32'h00EE_0000, 4'h4, 4'd0,  1'b0, 32'h0,         1};
      vecs[3] = '{32'h10, 32'h0,         4'h0, 4'd0,  1'b1, 32'hA5EE_1234, 1};
      vecs[4] = '{32'h0,  32'h1122_3344, 4'hF, 4'd1,  1'b0, 32'h0,         2};
      vecs[5] = '{32'h0,  32'h0,         4'h0, 4'd3,  1'b0, 32'h1122_3344, 4};
      vecs[6] = '{32'h10, 32'h0,         4'h0, 4'd15, 1'b0, 32'hA5EE_1234, 8};

      reset            = 1'b1;
      wait_cycles      = 4'd0;
      bus_if.mem_valid = 1'b0;
      bus_if.mem_instr = 1'b0;
      bus_if.mem_addr  = 32'd0;
      bus_if.mem_wdata = 32'd0;
      bus_if.mem_wstrb = 4'd0;
      #1;
      check32("reset ready", {31'd0, bus_if.mem_ready}, 32'd0);
      check32("reset rdata", bus_if.mem_rdata, 32'd0);
      check32("reset errs", {30'd0, protocol_err, range_err}, 32'd0);
      check32("reset txn", txn_count, 32'd0);
      check32("reset fetch", fetch_count, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 7; i++) begin
         run_txn($sformatf("vec%0d", i), vecs[i]);
         check32($sformatf("vec%0d txn", i), txn_count, 32'(i + 1));
      end
      check32("table fetch", fetch_count, 32'd1);
      check32("table errs", {30'd0, protocol_err, range_err}, 32'd0);

      // Valid held high across RESP: second accept in the mandatory IDLE cycle.
      v = '{32'h0, 32'h0, 4'h0, 4'd0, 1'b0, 32'h1122_3344, 1};
      set_req(v);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         rdy_seen[i] = bus_if.mem_ready;
      end
      bus_if.mem_valid = 1'b0;
      check32("b2b ready pattern", {28'd0, rdy_seen}, 32'h5);
      check32("b2b no perr", {31'd0, protocol_err}, 32'd0);
      check32("b2b txn", txn_count, 32'd9);
      @(posedge clk);
      #1;

      // Drop mem_valid during WAIT: still completes with the latched request.
      v = '{32'h10, 32'h0, 4'h0, 4'd2, 1'b0, 32'h0, 0};
      set_req(v);
      @(posedge clk);
      #1;
      bus_if.mem_valid = 1'b0;
      bus_if.mem_addr  = 32'h44;
      wait_ready(lat);
      check32("drop latency", 32'(lat), 32'd2);
      check32("drop rdata", bus_if.mem_rdata, 32'hA5EE_1234);
      check32("drop perr", {31'd0, protocol_err}, 32'd1);
      check32("drop txn", txn_count, 32'd10);
      repeat (3) @(posedge clk);
      #1;
      check32("perr sticky", {31'd0, protocol_err}, 32'd1);
      check32("drop no rerr", {31'd0, range_err}, 32'd0);

      // Out-of-range read and write; word 0 must survive the dropped write.
      v = '{32'h400, 32'h0, 4'h0, 4'd0, 1'b0, 32'hDEAD_BEEF, 1};
      run_txn("oor read", v);
      check32("oor rerr", {31'd0, range_err}, 32'd1);
      v = '{32'h400, 32'hFFFF_FFFF, 4'hF, 4'd0, 1'b0, 32'h0, 1};
      run_txn("oor write", v);
      v = '{32'h0, 32'h0, 4'h0, 4'd0, 1'b0, 32'h1122_3344, 1};
      run_txn("word0 intact", v);
      check32("oor txn", txn_count, 32'd13);

      // Reset asserted during WAIT of a write abandons it.
      v = '{32'h10, 32'h0, 4'hF, 4'd5, 1'b0, 32'h0, 0};
      set_req(v);
      repeat (2) @(posedge clk);
      #1;
      reset            = 1'b1;
      bus_if.mem_valid = 1'b0;
      #1;
      check32("rst ready", {31'd0, bus_if.mem_ready}, 32'd0);
      check32("rst txn async", txn_count, 32'd0);
      check32("rst errs async", {30'd0, protocol_err, range_err}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      v = '{32'h10, 32'h0, 4'h0, 4'd0, 1'b0, 32'hA5EE_1234, 1};
      run_txn("after rst read", v);
      check32("after rst txn", txn_count, 32'd1);
      check32("after rst fetch", fetch_count, 32'd0);
      check32("after rst errs", {30'd0, protocol_err, range_err}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/picorv32_mem_responder.md
Name: picorv32_mem_responder

Overview:
- Bus-side memory model that sits directly upstream of the picorv32 core in the formal and simulation benches.
- Answers the core's native mem_valid/mem_ready interface from a word-addressed internal array.
- Inserts a programmable number of wait states per transaction.
- Flags protocol and address-range violations, and counts completed transfers, so bench assertions can use them.

Parameters:
- ADDR_WIDTH, 8, log2 of memory depth in 32-bit words (256 words default)
- MAX_WAIT, 7, upper bound on wait states; larger wait_cycles requests are clamped to this value
- ERR_RDATA, 32'hDEADBEEF, read data returned for out-of-range reads

Ports:
- clk  input  1  sole clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- wait_cycles  input  4  wait states to insert for the next accepted request; sampled only at acceptance
- mem_valid  input  1  core request valid
- mem_instr  input  1  core request is an instruction fetch (counted only, no functional effect)
- mem_addr  input  32  byte address; bits [1:0] ignored
- mem_wdata  input  32  write data
- mem_wstrb  input  4  byte write enables; 0 = read
- mem_ready  output  1  registered one-cycle transfer-complete strobe
- mem_rdata  output  32  read data, valid only while mem_ready=1, else 0
- protocol_err  output  1  sticky: request dropped or changed while outstanding
- range_err  output  1  sticky: access to a word index >= 2**ADDR_WIDTH
- txn_count  output  32  completed transfers, wraps at 2**32
- fetch_count  output  32  completed transfers with mem_instr=1, wraps

Behaviour:
- Reset (async assert, synchronous deassert at the clk edge):
  - state=IDLE; mem_ready=0; mem_rdata=0.
  - protocol_err=0, range_err=0, txn_count=0, fetch_count=0.
  - Memory contents are NOT cleared by reset; the array is initialised to zero at time 0 only.
- States: IDLE, WAIT, RESP.
- IDLE:
  - When mem_valid=1, latch addr, wdata, wstrb and instr.
  - Load the wait counter with N = min(wait_cycles, MAX_WAIT).
  - N=0 goes to RESP; N>0 goes to WAIT.
- WAIT:
  - Decrement the counter each cycle; go to RESP on the edge where the counter reaches 0.
  - Each cycle, compare the live inputs against the latched request. If mem_valid=0 or mem_addr/mem_wstrb/mem_wdata differ, set protocol_err.
  - The transaction still completes with the latched values.
- Transition into RESP (on that same edge):
  - Register mem_ready=1.
  - Word index idx = latched addr[ADDR_WIDTH+1:2], checked against addr[31:ADDR_WIDTH+2].
  - Reads (wstrb=0): mem_rdata = mem[idx], or ERR_RDATA with range_err set if out of range.
  - Writes: each byte lane b with wstrb[b]=1 updates mem[idx][8b+7:8b]; mem_rdata=0. Out-of-range writes are dropped and set range_err.
  - txn_count increments; fetch_count increments if instr=1.
- RESP:
  - mem_ready=1 for exactly this one cycle.
  - Next state is always IDLE; mem_ready and mem_rdata return to 0.
- Handshake and latency:
  - A request accepted in cycle T sees mem_ready=1 in cycle T+1+N.
  - Back-to-back: a request held or re-asserted in the IDLE cycle after RESP is accepted normally. No bubble beyond the mandatory IDLE cycle, so minimum throughput is one transfer per 2 cycles.
  - Because the core drops mem_valid after mem_ready, a new accept right after RESP is legal.
  - If mem_valid is still high in that IDLE cycle, it is treated as a new transaction; no error.
- Simultaneous events:
  - protocol_err and range_err may set in the same cycle.
  - A txn_count wrap from 32'hFFFFFFFF goes to 0 with no flag.
- Reset mid-operation:
  - An outstanding transaction is abandoned: no memory write, no count increment, mem_ready forced low immediately.
- wait_cycles changing while in WAIT has no effect on the current transaction.

Test Plan:
- Write mem_addr=0x10, wdata=0xA5A5_1234, wstrb=4'hF, wait_cycles=0; then read 0x10 -> first mem_ready at T+1, read returns 0xA5A51234 with mem_ready at T'+1, txn_count=2.
- Partial write wstrb=4'b0100, wdata=0x00EE_0000 to 0x10; read back -> 0xA5EE1234.
- wait_cycles=3 read -> mem_ready exactly 4 cycles after accept, single-cycle pulse. wait_cycles=15 -> clamped, ready at accept+8.
- Drop mem_valid during WAIT (wait_cycles=2) -> protocol_err=1 and stays 1; the transfer still completes and txn_count increments.
- Read addr 0x0000_0400 (word 256, ADDR_WIDTH=8) -> mem_rdata=0xDEADBEEF, range_err=1. Write there, then read word 0 -> word 0 unchanged.
- Assert reset during WAIT of a write -> mem_ready=0 immediately, target word unchanged, counters and errors 0 after release.
